// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART frame arbiter.
// UART_ARB_CHECKSUM_EN selects the six-byte frame with a trailing XOR checksum.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO
    } arb_state_t;

    localparam logic [7:0] HDR_BYTE_DEF    = 8'h7B;
    localparam int         FRAME_LEN_BASE  = 5;
    localparam int         FRAME_LEN_CSUM  = 6;
    localparam int         WAIT_HI_TIMEOUT = 4;

`ifdef UART_ARB_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       idx,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = 3'(j);
            end
        end
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that serialises one requester's 24-bit payload into a
// framed byte stream for an external byte transmitter. Build option: UART_ARB_CHECKSUM_EN.
module uart_frame_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ    = 4,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic                  clk_20m,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [24*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ack,
    output logic [7:0]            tx_byte,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  frame_busy,
    output logic [2:0]            grant_id
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
    localparam logic [2:0] TO_LAST  = 3'(WAIT_HI_TIMEOUT - 1);

    arb_state_t       state, state_nx;
    logic [23:0]      payload;
    logic [2:0]       byte_idx;
    logic [2:0]       to_cnt;
    logic [2:0]       rr_ptr;
    logic             armed;
    logic             grant_en, idx_inc, cnt_inc;
    logic [N_REQ-1:0] win_oh;
    logic [2:0]       win_idx;
    logic             win_any;
    logic [7:0]       cur_byte;
    logic             last_byte;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign last_byte = (byte_idx == LAST_IDX);

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        idx_inc  = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state)
            // armed holds off the first grant by one edge after reset release
            IDLE: if (armed && win_any) begin
                grant_en = 1'b1;
                state_nx = LOAD;
            end
            LOAD:  if (!tx_busy) state_nx = START;
            START: state_nx = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy)                 state_nx = WAIT_LO;
                else if (to_cnt == TO_LAST)  state_nx = LOAD;
                else                         cnt_inc  = 1'b1;
            end
            WAIT_LO: if (!tx_busy) begin
                idx_inc  = 1'b1;
                state_nx = last_byte ? IDLE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_20m) begin
        if (rst) begin
            state    <= IDLE;
            armed    <= 1'b0;
            req_ack  <= '0;
            payload  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            byte_idx <= '0;
            to_cnt   <= '0;
        end else begin
            state   <= state_nx;
            armed   <= 1'b1;
            req_ack <= '0;
            to_cnt  <= cnt_inc ? to_cnt + 3'd1 : 3'd0;
            if (grant_en) begin
                req_ack  <= win_oh;
                grant_id <= win_idx;
                payload  <= req_data[24*win_idx +: 24];
                rr_ptr   <= (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
                byte_idx <= '0;
            end
            if (idx_inc) byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
        end
    end

`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = {5'b0, grant_id} ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
`endif

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            3'd0:    cur_byte = HDR_BYTE;
            3'd1:    cur_byte = {5'b0, grant_id};
            3'd2:    cur_byte = payload[23:16];
            3'd3:    cur_byte = payload[15:8];
            3'd4:    cur_byte = payload[7:0];
`ifdef UART_ARB_CHECKSUM_EN
            3'd5:    cur_byte = csum;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    // byte_idx only moves on leaving WAIT_LO, so tx_byte is stable LOAD..WAIT_LO
    assign tx_byte    = (state == IDLE) ? 8'h00 : cur_byte;
    assign tx_start   = (state == START);
    assign frame_busy = (state != IDLE);

endmodule
